// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] BUBBLE_DEF   = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

  // One prefetched word: pc is the fetch address plus PC_STEP.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small power-of-two FIFO of fetched {pc, instruction} entries.
module prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  // Pointer/count next state; flush empties the FIFO in one edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Fetch stage: one-in-flight imem requests, prefetch FIFO, IF/ID register.
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] BUBBLE   = BUBBLE_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic          pend_q, pend_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;

  logic          acc, bypass;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_rdata;

  // Request is combinational so a zero-wait memory sustains one fetch per cycle;
  // gating with rst keeps it low for the whole reset window.
  always_comb begin
    imem_req  = rst && ((state_q == DROP) || pend_q || (fifo_count < DEPTH_C));
    imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    acc       = imem_req && imem_ack && (state_q == FETCH) && !branch_taken;
  end

  // Fetch PC and request FSM next state; branch overrides everything.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    pend_d      = pend_q;
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      pend_d     = 1'b0;
      if (imem_req && !imem_ack) begin
        state_d     = DROP;
        drop_addr_d = imem_addr;   // the stale request must stay on the bus
      end else begin
        state_d = FETCH;
      end
    end else if (state_q == DROP) begin
      if (imem_ack) state_d = FETCH;
    end else if (acc) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      pend_d     = 1'b0;
    end else if (imem_req) begin
      pend_d = 1'b1;
    end
  end

  // IF/ID register next state: branch, freeze, FIFO head, bypass, bubble.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (branch_taken) begin
      valid_d = 1'b0;
      instr_d = BUBBLE;
    end else if (freeze) begin
      // hold
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      pc_d     = fifo_rdata.pc;
      instr_d  = fifo_rdata.instr;
      valid_d  = 1'b1;
    end else if (acc) begin
      bypass  = 1'b1;
      pc_d    = fetch_pc_q + PC_STEP;
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
      instr_d = BUBBLE;
    end
    fifo_push  = acc && !bypass;
    fifo_wdata = '{pc: fetch_pc_q + PC_STEP, instr: imem_rdata};
  end

  // All stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      pend_q      <= 1'b0;
      pc_q        <= '0;
      instr_q     <= BUBBLE;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      pend_q      <= pend_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Requests are only raised with room, so a return never meets a full FIFO.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Scoreboard bench for if_stage_prefetch with a variable-latency memory model.
module tb_if_stage_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] pc, instruction;
  logic        valid;

  int n_chk = 0;
  int n_err = 0;
  int lat = 0;
  int wcnt;

  if_stage_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .pc(pc), .instruction(instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  // memory: ack once the request has waited lat cycles
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr | 32'hE000_0000;
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard state
  logic [63:0] sbq[$];
  logic [31:0] exp_fetch = 32'h0;
  logic        drop = 1'b0;
  logic [31:0] drop_addr = '0;
  logic        last_br = 1'b0, last_frz = 1'b0;
  logic [31:0] hold_pc = '0, hold_ins = '0;
  logic        hold_vld = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        seen_first = 1'b0;
  logic [31:0] first_pc = '0;

  // negedge: check outputs of the last edge, then record this cycle's events
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      sbq.delete();
      exp_fetch = 32'h0; drop = 1'b0; last_br = 1'b0; last_frz = 1'b0;
      prev_pend = 1'b0; seen_first = 1'b0;
    end else begin
      if (last_br) begin
        chk("br_valid", {31'b0, valid}, 32'd0);
        chk("br_bubble", instruction, 32'h0);
      end else if (last_frz) begin
        chk("frz_pc", pc, hold_pc);
        chk("frz_ins", instruction, hold_ins);
        chk("frz_valid", {31'b0, valid}, {31'b0, hold_vld});
      end else begin
        chk("valid", {31'b0, valid}, {31'b0, (sbq.size() != 0)});
        if (valid && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("pc", pc, e[63:32]);
          chk("ins", instruction, e[31:0]);
          if (!seen_first) begin first_pc = pc; seen_first = 1'b1; end
        end
        if (!valid) chk("bubble", instruction, 32'h0);
      end
      if (prev_pend) begin
        chk("req_hold", {31'b0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      hold_pc = pc; hold_ins = instruction; hold_vld = valid;
      last_br = branch_taken; last_frz = freeze;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (branch_taken) begin
        sbq.delete();
        drop = imem_req && !imem_ack;
        drop_addr = imem_addr;
        exp_fetch = branch_addr;
        seen_first = 1'b0;
      end else if (imem_req && imem_ack) begin
        if (drop) begin
          chk("drop_addr", imem_addr, drop_addr);
          drop = 1'b0;
        end else begin
          chk("fetch_addr", imem_addr, exp_fetch);
          sbq.push_back({imem_addr + 32'd4, imem_addr | 32'hE000_0000});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int l);
    step(); rst = 1'b0; lat = l;
    step(); step(); rst = 1'b1;
  endtask

  initial begin
    logic found;
    // reset state
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ins", instruction, 32'h0);
    chk("rst_pc", pc, 32'h0);

    // 1+2: zero-wait streaming, then freeze with pc=8 presented
    step(); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * i));
    end
    step(); freeze = 1'b1;
    @(negedge clk);
    chk("t1_addr", imem_addr, 32'h8);
    chk("t2_pc8", pc, 32'h8);
    repeat (6) step();
    chk("t2_req_low", {31'b0, imem_req}, 32'd0);
    chk("t2_count", 32'(dut.fifo_count), 32'd4);
    freeze = 1'b0;
    repeat (10) step();

    // 3: branch with two entries buffered
    freeze = 1'b1;
    step(); step();
    freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("t3_count", 32'(dut.fifo_count), 32'd0);
    chk("t3_addr", imem_addr, 32'h100);
    repeat (8) step();
    chk("t3_first", first_pc, 32'h104);

    // 4: slow memory, branch while a request to 0x20 is outstanding
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h20) found = 1'b1;
    end
    chk("t4_found", {31'b0, found}, 32'd1);
    step(); branch_taken = 1'b1; branch_addr = 32'h200;
    step(); branch_taken = 1'b0;
    repeat (20) step();
    chk("t4_first", first_pc, 32'h204);

    // 5: branch and freeze together
    lat = 0;
    repeat (4) step();
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h300;
    step(); freeze = 1'b0; branch_taken = 1'b0;
    repeat (8) step();
    chk("t5_first", first_pc, 32'h304);

    // 6: asynchronous reset in the middle of a slow request
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && !imem_ack) found = 1'b1;
    end
    chk("t6_found", {31'b0, found}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_valid", {31'b0, valid}, 32'd0);
    chk("t6_ins", instruction, 32'h0);
    lat = 0;
    step(); step(); rst = 1'b1;
    @(negedge clk);
    chk("t6_addr", imem_addr, 32'h0);
    repeat (8) step();
    chk("t6_first", first_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Instruction-fetch stage that produces the pc/instruction pair consumed by the decode stage. It owns the fetch PC and issues requests to a variable-latency instruction memory, allowing one request in flight at a time. Returned words are buffered in a small prefetch FIFO and presented through the IF/ID output register. The stage honours the hazard freeze and the branch redirect from the execute stage.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, at least 2)
BUBBLE, 32'h0000_0000, instruction word driven when the output is not valid
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; held stable while imem_req=1 and no ack
imem_ack  in  1  data valid; may arrive in the same cycle as the request (zero-wait) or later
imem_rdata  in  32  instruction word; qualified by imem_ack
freeze  in  1  hazard stall; the IF/ID register holds its value
branch_taken  in  1  single-cycle redirect from the execute stage
branch_addr  in  32  redirect target
pc  out  32  address of the presented instruction plus 4
instruction  out  32  presented instruction word
valid  out  1  pc and instruction are real, not a bubble

Behaviour:
- Reset values, applied asynchronously while rst=0:
  - fetch_pc=RESET_PC, FIFO empty, state=FETCH
  - imem_req=0, valid=0, pc=0, instruction=BUBBLE
- Request FSM, states FETCH and DROP:
  - FETCH: imem_req=1 and imem_addr=fetch_pc whenever count<DEPTH.
  - Once raised, imem_req stays high and imem_addr stays unchanged until imem_ack. The count<DEPTH check is made only when raising the request, so an in-flight return always has room.
  - Ack in FETCH without a branch: accept {fetch_pc+4, imem_rdata} and advance fetch_pc by 4 (32-bit wrap).
  - A new request may be raised in the cycle after the ack. With zero-wait memory this sustains 1 fetch per cycle.
- Branch (priority over everything except reset), on the edge where branch_taken=1:
  - FIFO flushed; valid←0; instruction←BUBBLE; pc held.
  - fetch_pc←branch_addr.
  - If imem_req=1 and imem_ack=0 that cycle: go to DROP.
  - DROP: the request stays at its old address until imem_ack. The returned data is discarded, then the FSM returns to FETCH and issues branch_addr.
  - An ack in the same cycle as branch_taken is discarded and causes no DROP.
  - A second branch while in DROP overwrites fetch_pc and stays in DROP.
- IF/ID output register, priority order:
  1. branch
  2. freeze → hold pc, instruction, valid
  3. FIFO non-empty → pop the head into the outputs, valid←1
  4. FIFO empty and an accepted ack this cycle → bypass the returned word directly into the outputs, valid←1; nothing is pushed
  5. otherwise valid←0, instruction←BUBBLE, pc held
- FIFO:
  - Push on an accepted ack unless that word is bypassed.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push when full is impossible by construction; an assertion checks it.
- Latency:
  - Zero-wait memory: an instruction requested in cycle n is valid at the outputs after the edge ending cycle n.
  - First valid output: the first edge after rst deasserts.
- Ordering: instructions leave in address order with no duplication or loss across freeze, full FIFO or memory latency.

Decomposition:
- if_pkg: BUBBLE and RESET_PC defaults, PC_STEP=4, enum fetch_state_t {FETCH, DROP}.
- Sub-module prefetch_fifo: DEPTH x 64 bits ({pc, instruction}), with push, pop, synchronous flush, count, empty and full. Same clk/rst convention.

Test Plan:
1. Zero-wait memory, mem[a]=a|32'hE000_0000, release rst → imem_addr 0,4,8,… on consecutive cycles. First valid output is pc=4, instruction=E000_0000, then pc=8,12,… with no gaps.
2. Zero-wait memory, freeze=1 for 6 cycles while pc=8 is presented → outputs hold pc=8, FIFO reaches 4, imem_req drops. After release: pc=12,16,20,24,28 on consecutive edges, no duplicate or lost entries.
3. FIFO holding 2 entries, branch_taken=1 with branch_addr=0x100 → next edge valid=0 and instruction=0, FIFO empty. Next imem_addr=0x100, then valid with pc=0x104.
4. 3-cycle-latency memory, branch to 0x200 one cycle after a request to 0x20 → imem_addr stays 0x20 until ack and that data never reaches the outputs. Next request is 0x200; output pc=0x204.
5. branch_taken=1 and freeze=1 in the same cycle → branch wins: valid=0 and the next fetch goes to branch_addr.
6. Drive rst=0 mid-request between clock edges → imem_req=0, valid=0 and instruction=0 immediately, with no clock edge. After release, fetch restarts at address 0.
